// File: rtl/glb_interrupt_ctrl.sv
// Sticky W1C interrupt status per tile for F2G/G2F/PCFG done pulses, masked and enabled into level interrupts.
// Latency: pulse->status 1 cycle, pulse->interrupt 2 cycles, read 1 cycle. No backpressure. Optional counters: GLB_INTR_CNT_EN.
module glb_interrupt_ctrl #(
    parameter int NUM_GLB_TILES  = 16,
    parameter int CFG_ADDR_WIDTH = 8,
    parameter int CFG_DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_GLB_TILES-1:0]  strm_f2g_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0]  strm_g2f_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0]  pcfg_g2f_interrupt_pulse,
    input  logic                      cfg_wr_en,
    input  logic                      cfg_rd_en,
    input  logic [CFG_ADDR_WIDTH-1:0] cfg_addr,
    input  logic [CFG_DATA_WIDTH-1:0] cfg_wr_data,
    output logic [CFG_DATA_WIDTH-1:0] cfg_rd_data,
    output logic                      cfg_rd_data_valid,
    output logic                      strm_f2g_interrupt,
    output logic                      strm_g2f_interrupt,
    output logic                      pcfg_g2f_interrupt,
    output logic                      glb_interrupt
);
    localparam int N  = NUM_GLB_TILES;
    localparam int AW = CFG_ADDR_WIDTH - 2;

    logic [AW-1:0] word;
    logic [N-1:0]  wr_bits;
    logic [N-1:0]  f2g_status, g2f_status, pcfg_status;
    logic [N-1:0]  f2g_mask, g2f_mask, pcfg_mask;
    logic [2:0]    ier;
    logic [2:0]    class_term;
    logic [CFG_DATA_WIDTH-1:0] rd_mux;
    logic          unused_bits;

    assign word        = cfg_addr[CFG_ADDR_WIDTH-1:2];
    assign wr_bits     = cfg_wr_data[N-1:0];
    assign unused_bits = ^{cfg_addr[1:0], cfg_wr_data};

    logic wr_f2g_st, wr_g2f_st, wr_pcfg_st, wr_f2g_mk, wr_g2f_mk, wr_pcfg_mk, wr_ier;
    assign wr_f2g_st  = cfg_wr_en && (word == AW'(0));
    assign wr_g2f_st  = cfg_wr_en && (word == AW'(1));
    assign wr_pcfg_st = cfg_wr_en && (word == AW'(2));
    assign wr_f2g_mk  = cfg_wr_en && (word == AW'(3));
    assign wr_g2f_mk  = cfg_wr_en && (word == AW'(4));
    assign wr_pcfg_mk = cfg_wr_en && (word == AW'(5));
    assign wr_ier     = cfg_wr_en && (word == AW'(6));

    // Clear is applied before OR-ing in the new pulses so a colliding set survives.
    always_ff @(posedge clk) begin
        if (reset) begin
            f2g_status  <= '0;
            g2f_status  <= '0;
            pcfg_status <= '0;
            f2g_mask    <= '0;
            g2f_mask    <= '0;
            pcfg_mask   <= '0;
            ier         <= '0;
        end else begin
            f2g_status  <= (f2g_status  & ~(wr_f2g_st  ? wr_bits : '0)) | strm_f2g_interrupt_pulse;
            g2f_status  <= (g2f_status  & ~(wr_g2f_st  ? wr_bits : '0)) | strm_g2f_interrupt_pulse;
            pcfg_status <= (pcfg_status & ~(wr_pcfg_st ? wr_bits : '0)) | pcfg_g2f_interrupt_pulse;
            if (wr_f2g_mk)  f2g_mask  <= wr_bits;
            if (wr_g2f_mk)  g2f_mask  <= wr_bits;
            if (wr_pcfg_mk) pcfg_mask <= wr_bits;
            if (wr_ier)     ier       <= cfg_wr_data[2:0];
        end
    end

    assign class_term[0] = ier[0] & (|(f2g_status  & f2g_mask));
    assign class_term[1] = ier[1] & (|(g2f_status  & g2f_mask));
    assign class_term[2] = ier[2] & (|(pcfg_status & pcfg_mask));

    always_ff @(posedge clk) begin
        if (reset) begin
            strm_f2g_interrupt <= 1'b0;
            strm_g2f_interrupt <= 1'b0;
            pcfg_g2f_interrupt <= 1'b0;
            glb_interrupt      <= 1'b0;
        end else begin
            strm_f2g_interrupt <= class_term[0];
            strm_g2f_interrupt <= class_term[1];
            pcfg_g2f_interrupt <= class_term[2];
            glb_interrupt      <= |class_term;
        end
    end

`ifdef GLB_INTR_CNT_EN
    logic [15:0] f2g_cnt, g2f_cnt, pcfg_cnt;
    logic        cnt_frz;

    function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [N-1:0] p);
        logic [16:0] s;
        s = {1'b0, c} + 17'($countones(p));
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // A write clears even while frozen; the freeze only stops accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            f2g_cnt  <= '0;
            g2f_cnt  <= '0;
            pcfg_cnt <= '0;
            cnt_frz  <= 1'b0;
        end else begin
            if (cfg_wr_en && (word == AW'(7)))      f2g_cnt <= '0;
            else if (!cnt_frz)                      f2g_cnt <= sat_add(f2g_cnt, strm_f2g_interrupt_pulse);
            if (cfg_wr_en && (word == AW'(8)))      g2f_cnt <= '0;
            else if (!cnt_frz)                      g2f_cnt <= sat_add(g2f_cnt, strm_g2f_interrupt_pulse);
            if (cfg_wr_en && (word == AW'(9)))      pcfg_cnt <= '0;
            else if (!cnt_frz)                      pcfg_cnt <= sat_add(pcfg_cnt, pcfg_g2f_interrupt_pulse);
            if (cfg_wr_en && (word == AW'(10)))     cnt_frz <= cfg_wr_data[0];
        end
    end
`endif

    always_comb begin
        rd_mux = '0;
        case (word)
            AW'(0): rd_mux = CFG_DATA_WIDTH'(f2g_status);
            AW'(1): rd_mux = CFG_DATA_WIDTH'(g2f_status);
            AW'(2): rd_mux = CFG_DATA_WIDTH'(pcfg_status);
            AW'(3): rd_mux = CFG_DATA_WIDTH'(f2g_mask);
            AW'(4): rd_mux = CFG_DATA_WIDTH'(g2f_mask);
            AW'(5): rd_mux = CFG_DATA_WIDTH'(pcfg_mask);
            AW'(6): rd_mux = CFG_DATA_WIDTH'(ier);
`ifdef GLB_INTR_CNT_EN
            AW'(7):  rd_mux = CFG_DATA_WIDTH'(f2g_cnt);
            AW'(8):  rd_mux = CFG_DATA_WIDTH'(g2f_cnt);
            AW'(9):  rd_mux = CFG_DATA_WIDTH'(pcfg_cnt);
            AW'(10): rd_mux = CFG_DATA_WIDTH'(cnt_frz);
`endif
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_rd_data       <= '0;
            cfg_rd_data_valid <= 1'b0;
        end else begin
            cfg_rd_data_valid <= cfg_rd_en;
            if (cfg_rd_en) cfg_rd_data <= rd_mux;
        end
    end
endmodule

// File: tb/tb_glb_interrupt_ctrl.sv
// Directed bench for glb_interrupt_ctrl with a per-cycle register-level reference model.
module tb_glb_interrupt_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] f2g_p, g2f_p, pcfg_p;
    logic        cfg_wr_en, cfg_rd_en;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wr_data;
    logic [31:0] cfg_rd_data;
    logic        cfg_rd_data_valid;
    logic        f2g_int, g2f_int, pcfg_int, glb_int;

    int checks = 0;
    int failures = 0;

    glb_interrupt_ctrl dut (
        .clk(clk), .reset(reset),
        .strm_f2g_interrupt_pulse(f2g_p),
        .strm_g2f_interrupt_pulse(g2f_p),
        .pcfg_g2f_interrupt_pulse(pcfg_p),
        .cfg_wr_en(cfg_wr_en), .cfg_rd_en(cfg_rd_en),
        .cfg_addr(cfg_addr), .cfg_wr_data(cfg_wr_data),
        .cfg_rd_data(cfg_rd_data), .cfg_rd_data_valid(cfg_rd_data_valid),
        .strm_f2g_interrupt(f2g_int), .strm_g2f_interrupt(g2f_int),
        .pcfg_g2f_interrupt(pcfg_int), .glb_interrupt(glb_int)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    localparam logic [31:0] TM = 32'h0000_FFFF;
    logic [31:0] m_status [3];
    logic [31:0] m_mask   [3];
    logic [31:0] m_ier;
    int          m_cnt    [3];
    logic        m_frz;
    logic [3:0]  e_int;
    logic        e_valid;
    logic [31:0] e_data;
    bit          model_ok = 0;

    function automatic logic [31:0] m_read(input logic [7:0] a);
        case (a & 8'hFC)
            8'h00: return m_status[0];
            8'h04: return m_status[1];
            8'h08: return m_status[2];
            8'h0C: return m_mask[0];
            8'h10: return m_mask[1];
            8'h14: return m_mask[2];
            8'h18: return m_ier;
`ifdef GLB_INTR_CNT_EN
            8'h1C: return m_cnt[0];
            8'h20: return m_cnt[1];
            8'h24: return m_cnt[2];
            8'h28: return {31'b0, m_frz};
`endif
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [15:0] p [3];
        logic [7:0]  a;
        p[0] = f2g_p; p[1] = g2f_p; p[2] = pcfg_p;
        a = cfg_addr & 8'hFC;
        if (reset) begin
            for (int c = 0; c < 3; c++) begin
                m_status[c] = 0; m_mask[c] = 0; m_cnt[c] = 0;
            end
            m_ier = 0; m_frz = 0; e_int = 0; e_valid = 0; e_data = 0;
        end else begin
            for (int c = 0; c < 3; c++)
                e_int[c] = m_ier[c] && ((m_status[c] & m_mask[c]) != 0);
            e_int[3] = |e_int[2:0];
            e_valid = cfg_rd_en;
            if (cfg_rd_en) e_data = m_read(cfg_addr);
            for (int c = 0; c < 3; c++) begin
                if (cfg_wr_en && a == 8'(4 * c))     m_status[c] = m_status[c] & ~cfg_wr_data;
                if (cfg_wr_en && a == 8'(12 + 4 * c)) m_mask[c] = cfg_wr_data & TM;
                m_status[c] = m_status[c] | {16'b0, p[c]};
            end
            if (cfg_wr_en && a == 8'h18) m_ier = cfg_wr_data & 32'h7;
            for (int c = 0; c < 3; c++) begin
                if (cfg_wr_en && a == 8'(8'h1C + 4 * c)) m_cnt[c] = 0;
                else if (!m_frz) m_cnt[c] = (m_cnt[c] + $countones(p[c]) > 65535) ? 65535 : m_cnt[c] + $countones(p[c]);
            end
            if (cfg_wr_en && a == 8'h28) m_frz = cfg_wr_data[0];
        end
        model_ok = 1;
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_f2g_int",  {31'b0, f2g_int},  {31'b0, e_int[0]});
            chk("m_g2f_int",  {31'b0, g2f_int},  {31'b0, e_int[1]});
            chk("m_pcfg_int", {31'b0, pcfg_int}, {31'b0, e_int[2]});
            chk("m_glb_int",  {31'b0, glb_int},  {31'b0, e_int[3]});
            chk("m_rd_valid", {31'b0, cfg_rd_data_valid}, {31'b0, e_valid});
            chk("m_rd_data",  cfg_rd_data, e_data);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        cfg_wr_en = 1; cfg_addr = a; cfg_wr_data = d;
        step();
        cfg_wr_en = 0;
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [31:0] exp, input string nm);
        cfg_rd_en = 1; cfg_addr = a;
        step();
        cfg_rd_en = 0;
        chk(nm, cfg_rd_data, exp);
        chk({nm, "_valid"}, {31'b0, cfg_rd_data_valid}, 32'h1);
    endtask

    initial begin
        reset = 1; f2g_p = 0; g2f_p = 0; pcfg_p = 0;
        cfg_wr_en = 0; cfg_rd_en = 0; cfg_addr = 0; cfg_wr_data = 0;
        step(); step();
        reset = 0;
        chk("rst_ints", {28'b0, glb_int, pcfg_int, g2f_int, f2g_int}, 32'h0);
        chk("rst_valid", {31'b0, cfg_rd_data_valid}, 32'h0);
        for (int i = 0; i < 7; i++) rd_chk(8'(4 * i), 32'h0, "rst_reg");

        // F2G set, interrupt latency, W1C deassert
        wr(8'h18, 32'h1);
        wr(8'h0C, 32'hFFFF);
        f2g_p = 16'h0008;
        step();
        f2g_p = 0;
        chk("f2g_int_e1", {31'b0, f2g_int}, 32'h0);
        rd_chk(8'h00, 32'h8, "f2g_status");
        chk("f2g_int_e2", {31'b0, f2g_int}, 32'h1);
        chk("glb_int_e2", {31'b0, glb_int}, 32'h1);
        wr(8'h00, 32'h8);
        chk("f2g_int_w1", {31'b0, f2g_int}, 32'h1);
        step();
        chk("f2g_int_w2", {31'b0, f2g_int}, 32'h0);
        chk("glb_int_w2", {31'b0, glb_int}, 32'h0);

        // set wins over W1C on the same bit
        g2f_p = 16'h0010;
        step();
        cfg_wr_en = 1; cfg_addr = 8'h04; cfg_wr_data = 32'h10;
        step();
        cfg_wr_en = 0; g2f_p = 0;
        rd_chk(8'h04, 32'h10, "g2f_collide");
        wr(8'h04, 32'h10);
        rd_chk(8'h04, 32'h0, "g2f_cleared");

        // masked PCFG, then unmask
        wr(8'h18, 32'h4);
        wr(8'h14, 32'h1);
        pcfg_p = 16'h0020;
        step();
        pcfg_p = 0;
        step();
        chk("pcfg_masked", {31'b0, pcfg_int}, 32'h0);
        rd_chk(8'h08, 32'h20, "pcfg_status");
        wr(8'h14, 32'h20);
        chk("pcfg_unmask0", {31'b0, pcfg_int}, 32'h0);
        step();
        chk("pcfg_unmask1", {31'b0, pcfg_int}, 32'h1);
        chk("pcfg_glb", {31'b0, glb_int}, 32'h1);

        // unmapped addresses and register widths
        rd_chk(8'h40, 32'h0, "unmapped_rd");
        wr(8'h40, 32'hFFFF_FFFF);
        rd_chk(8'h0C, 32'hFFFF, "f2g_mask_keep");
        rd_chk(8'h14, 32'h20, "pcfg_mask_keep");
        rd_chk(8'h18, 32'h4, "ier_keep");
        wr(8'h10, 32'hFFFF_FFFF);
        rd_chk(8'h10, 32'hFFFF, "g2f_mask_width");
        wr(8'h18, 32'hFFFF_FFFF);
        rd_chk(8'h18, 32'h7, "ier_width");

        // simultaneous read and write returns the old value
        cfg_wr_en = 1; cfg_rd_en = 1; cfg_addr = 8'h0C; cfg_wr_data = 32'h1;
        step();
        cfg_wr_en = 0; cfg_rd_en = 0;
        chk("rdwr_old", cfg_rd_data, 32'hFFFF);
        rd_chk(8'h0C, 32'h1, "rdwr_new");

        // held pulse acts as one pulse
        f2g_p = 16'h0001;
        step(); step(); step();
        f2g_p = 0;
        rd_chk(8'h00, 32'h1, "held_pulse");

        // reset mid-operation drops the in-flight read
        reset = 1; cfg_rd_en = 1; cfg_addr = 8'h08; g2f_p = 16'h0002;
        step();
        reset = 0; cfg_rd_en = 0; g2f_p = 0;
        chk("midrst_valid", {31'b0, cfg_rd_data_valid}, 32'h0);
        chk("midrst_ints", {28'b0, glb_int, pcfg_int, g2f_int, f2g_int}, 32'h0);
        rd_chk(8'h08, 32'h0, "midrst_pcfg");
        rd_chk(8'h04, 32'h0, "midrst_g2f");
        rd_chk(8'h18, 32'h0, "midrst_ier");

`ifdef GLB_INTR_CNT_EN
        f2g_p = 16'hFFFF;
        repeat (5000) step();
        f2g_p = 0;
        rd_chk(8'h1C, 32'hFFFF, "cnt_sat");
        wr(8'h1C, 32'h0);
        rd_chk(8'h1C, 32'h0, "cnt_clr");
        wr(8'h28, 32'h1);
        f2g_p = 16'h00FF;
        step();
        f2g_p = 0;
        wr(8'h28, 32'h0);
        rd_chk(8'h1C, 32'h0, "cnt_frozen");
        f2g_p = 16'h0007;
        step();
        f2g_p = 0;
        rd_chk(8'h1C, 32'h3, "cnt_add");
        f2g_p = 16'h000F; cfg_wr_en = 1; cfg_addr = 8'h1C; cfg_wr_data = 0;
        step();
        f2g_p = 0; cfg_wr_en = 0;
        rd_chk(8'h1C, 32'h0, "cnt_clr_wins");
        pcfg_p = 16'h0003;
        step();
        pcfg_p = 0;
        rd_chk(8'h24, 32'h2, "pcfg_cnt");
`else
        f2g_p = 16'hFFFF;
        step();
        f2g_p = 0;
        rd_chk(8'h1C, 32'h0, "nocnt_rd");
        wr(8'h1C, 32'hFFFF_FFFF);
        rd_chk(8'h1C, 32'h0, "nocnt_wr");
        wr(8'h28, 32'h1);
        rd_chk(8'h28, 32'h0, "nocnt_ctrl");
`endif
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/glb_interrupt_ctrl.md
Name: glb_interrupt_ctrl

Overview:
- Collects the per-tile interrupt pulses produced by every global-buffer tile: stream F2G done, stream G2F done, and parallel-config G2F done.
- Latches them into sticky, write-1-to-clear status registers.
- Drives one level interrupt per class, plus a combined interrupt, to the processor.
- Sits at the GLB top level, downstream of the tile array, with a simple word-addressed register port from the GLB config controller.

Parameters:
- NUM_GLB_TILES, 16, number of tiles; legal 1..32.
- CFG_ADDR_WIDTH, 8, byte address width of the register port.
- CFG_DATA_WIDTH, 32, register data width; must be >= NUM_GLB_TILES.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- strm_f2g_interrupt_pulse  in  NUM_GLB_TILES  per-tile one-cycle done pulses, stream F2G.
- strm_g2f_interrupt_pulse  in  NUM_GLB_TILES  per-tile one-cycle done pulses, stream G2F.
- pcfg_g2f_interrupt_pulse  in  NUM_GLB_TILES  per-tile one-cycle done pulses, parallel config.
- cfg_wr_en  in  1  register write strobe.
- cfg_rd_en  in  1  register read strobe.
- cfg_addr  in  CFG_ADDR_WIDTH  byte address; bits [1:0] ignored.
- cfg_wr_data  in  CFG_DATA_WIDTH  write data.
- cfg_rd_data  out  CFG_DATA_WIDTH  read data.
- cfg_rd_data_valid  out  1  read data valid, one-cycle pulse.
- strm_f2g_interrupt  out  1  level interrupt, class F2G.
- strm_g2f_interrupt  out  1  level interrupt, class G2F.
- pcfg_g2f_interrupt  out  1  level interrupt, class PCFG.
- glb_interrupt  out  1  OR of the three class interrupts.

Behaviour:
- Clock and reset: clk is the only clock; reset is synchronous and active-high.
- Reset values: all status, enable and mask registers are 0. cfg_rd_data, cfg_rd_data_valid and all four interrupt outputs are 0.
- Register map (byte offsets):
  - 0x00 F2G_STATUS, W1C.
  - 0x04 G2F_STATUS, W1C.
  - 0x08 PCFG_STATUS, W1C.
  - 0x0C F2G_MASK, RW.
  - 0x10 G2F_MASK, RW.
  - 0x14 PCFG_MASK, RW.
  - 0x18 IER, RW, bits [2:0] = {PCFG, G2F, F2G} class enables.
  - 0x1C..0x28: counters, see Optional Feature.
- Register width rules: bits at or above NUM_GLB_TILES in status and mask registers read 0 and ignore writes. IER bits [31:3] read 0.
- Status set: pulse bit t high at edge E sets status[t] at E, visible the cycle after. A pulse held for k cycles is equivalent to one pulse.
- Status clear: a write to a status register clears the bits where cfg_wr_data is 1, at the write edge.
- Set/clear collision: if a set and a W1C clear hit the same bit at the same edge, set wins and the bit stays 1.
- Class interrupt: class_int = IER[c] & |(status_c & mask_c). It is registered, so it asserts one cycle after the status bit becomes visible. Total latency from pulse edge to output is 2 cycles.
- Combined interrupt: glb_interrupt is the registered OR of the three class terms and has the same latency.
- Deassertion: a class interrupt deasserts one cycle after the last contributing status bit clears, or after its mask bit or IER bit is cleared.
- Reads: cfg_rd_en at edge E gives cfg_rd_data and cfg_rd_data_valid=1 during the following cycle. Otherwise cfg_rd_data_valid=0 and cfg_rd_data holds its last value.
- Unmapped addresses: reads return 0 with valid=1; writes are ignored.
- Simultaneous read and write: cfg_wr_en and cfg_rd_en may both be high. The write is performed and the read returns the pre-write value.
- Reset mid-operation: all state clears; any pulse or access in the reset cycle is dropped. An in-flight read returns no valid.

Optional Feature:
- Macro: GLB_INTR_CNT_EN.
- When defined:
  - Three 16-bit event counters: 0x1C F2G_CNT, 0x20 G2F_CNT, 0x24 PCFG_CNT.
  - Each counter adds the popcount of its class pulse vector every cycle.
  - Counters saturate at 0xFFFF; an addition that would overflow yields 0xFFFF.
  - Any write to a counter address clears it to 0. If a clear and an increment land in the same cycle, the clear wins and the pulses that cycle are dropped.
  - 0x28 CNT_CTRL bit0 freezes all counters while 1.
- When undefined:
  - 0x1C..0x28 read 0 and ignore writes.
  - No counter logic is synthesized.

Test Plan:
- Reset, then read 0x00..0x18 -> all 0, valid one cycle after each cfg_rd_en; all interrupts 0.
- IER=0x1, F2G_MASK=0xFFFF, pulse strm_f2g bit 3 at edge E -> F2G_STATUS=0x0008 from E+1; strm_f2g_interrupt and glb_interrupt high from E+2. Write 0x0008 to 0x00 -> interrupt low 2 cycles after write edge.
- W1C of 0x0010 to 0x04 in the same cycle as a pulse on g2f bit 4 -> G2F_STATUS bit 4 stays 1.
- PCFG_MASK=0x0001, pulse pcfg bit 5 with IER=0x4 -> PCFG_STATUS=0x0020, pcfg_g2f_interrupt stays 0. Write PCFG_MASK=0x0020 -> interrupt asserts 1 cycle later.
- Read 0x40 -> data 0 with valid=1. Write 0x40 with 0xFFFFFFFF -> no register changes.
- GLB_INTR_CNT_EN defined: pulse all 16 f2g bits for 5000 cycles -> F2G_CNT=0xFFFF. Write 0x1C -> reads 0. Without the macro, 0x1C reads 0.
